// File: rtl/down_fifo_pattern_gen.sv
// Write-side traffic source for the DMA down FIFO: emits a programmable run of
// pattern words under full-flag backpressure, optionally repeating one word.
module down_fifo_pattern_gen #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        mode_i,
   input  logic [DATA_W-1:0] seed_i,
   input  logic [CNT_W-1:0]  length_i,
   input  logic              dup_inject_i,
   input  logic [CNT_W-1:0]  dup_index_i,
   input  logic              fifo_full_i,
   output logic              fifo_wr_en_o,
   output logic [DATA_W-1:0] fifo_wr_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  words_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [1:0]        MODE_INC  = 2'b00;
   localparam logic [1:0]        MODE_DEC  = 2'b01;
   localparam logic [1:0]        MODE_LFSR = 2'b10;
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h0040_0007);

   state_t              state_q;
   logic [1:0]          mode_q;
   logic [CNT_W-1:0]    len_q;
   logic                dup_en_q;
   logic [CNT_W-1:0]    dup_idx_q;
   logic [DATA_W-1:0]   data_q;
   logic [CNT_W-1:0]    words_q;
   logic [CNT_W-1:0]    stall_q;
   logic [DATA_W-1:0]   data_next;
   logic [DATA_W-1:0]   seed_fixed;
   logic                accept;

   // LFSR and walking-one would lock up on an all-zero word, so seed 0 becomes 1
   assign seed_fixed = (mode_i[1] && seed_i == '0) ? DATA_W'(1) : seed_i;

   always_comb begin
      data_next = data_q;
      case (mode_q)
         MODE_INC:  data_next = data_q + DATA_W'(1);
         MODE_DEC:  data_next = data_q - DATA_W'(1);
         MODE_LFSR: data_next = {data_q[DATA_W-2:0], 1'b0} ^ (data_q[DATA_W-1] ? LFSR_TAPS : '0);
         default:   data_next = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
      endcase
   end

   // The full flag and abort gate the write in the same cycle
   assign accept         = (state_q == RUN) && !fifo_full_i && !abort_i;
   assign fifo_wr_en_o   = accept;
   assign fifo_wr_data_o = data_q;
   assign busy_o         = (state_q == LOAD) || (state_q == RUN);
   assign done_o         = (state_q == DONE) && !abort_i;
   assign words_o        = words_q;
   assign stall_cnt_o    = stall_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         mode_q    <= MODE_INC;
         len_q     <= '0;
         dup_en_q  <= 1'b0;
         dup_idx_q <= '0;
         data_q    <= '0;
         words_q   <= '0;
         stall_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && !abort_i) state_q <= LOAD;
            end
            LOAD: begin
               if (abort_i) begin
                  state_q <= IDLE;
               end else begin
                  mode_q    <= mode_i;
                  len_q     <= length_i;
                  dup_en_q  <= dup_inject_i;
                  dup_idx_q <= dup_index_i;
                  data_q    <= seed_fixed;
                  words_q   <= '0;
                  stall_q   <= '0;
                  state_q   <= (length_i == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (abort_i) begin
                  state_q <= IDLE;
               end else if (fifo_full_i) begin
                  if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
               end else begin
                  words_q <= words_q + CNT_W'(1);
                  // Holding the data reg on the chosen index repeats that word once
                  if (!(dup_en_q && words_q == dup_idx_q)) data_q <= data_next;
                  if (words_q == len_q - CNT_W'(1)) state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_down_fifo_pattern_gen.sv
// Scoreboard bench for down_fifo_pattern_gen: expected words are queued when a
// run is launched and popped as the FIFO write port fires.
module tb_down_fifo_pattern_gen;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [1:0]  mode_i = 2'b00;
   logic [31:0] seed_i = '0;
   logic [15:0] length_i = '0;
   logic        dup_inject_i = 1'b0;
   logic [15:0] dup_index_i = '0;
   logic        fifo_full_i = 1'b0;
   logic        fifo_wr_en_o;
   logic [31:0] fifo_wr_data_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] words_o;
   logic [15:0] stall_cnt_o;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          writes_seen = 0;
   int          done_seen = 0;
   int          done_cyc = -1;
   logic [31:0] exp_q[$];

   down_fifo_pattern_gen #(.DATA_W(32), .CNT_W(16)) dut (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .mode_i         (mode_i),
      .seed_i         (seed_i),
      .length_i       (length_i),
      .dup_inject_i   (dup_inject_i),
      .dup_index_i    (dup_index_i),
      .fifo_full_i    (fifo_full_i),
      .fifo_wr_en_o   (fifo_wr_en_o),
      .fifo_wr_data_o (fifo_wr_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .words_o        (words_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic logic [31:0] modelNext(input logic [1:0] mode, input logic [31:0] d);
      case (mode)
         2'b00:   return d + 32'd1;
         2'b01:   return d - 32'd1;
         2'b10:   return d[31] ? ({d[30:0], 1'b0} ^ 32'h0040_0007) : {d[30:0], 1'b0};
         default: return {d[30:0], d[31]};
      endcase
   endfunction

   // Writes are scored on the falling edge, away from the active edge
   always @(negedge clk_i) begin
      if (fifo_wr_en_o === 1'b1) begin
         writes_seen++;
         if (exp_q.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
         else checkOutput("wr_data", fifo_wr_data_o, exp_q.pop_front());
      end
      if (done_o === 1'b1) begin
         done_seen++;
         done_cyc = cyc;
      end
   end

   // stop_kind: 0 = run to completion, 1 = abort, 2 = async reset, after stop_after writes
   task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] seed, input logic [15:0] len,
                                input logic dup, input logic [15:0] idx, input logic [31:0] plan,
                                input int stop_kind, input int stop_after);
      logic [31:0] d;
      int stalls, w, k, t0, budget, exp_writes;
      bit stopped;
      exp_q.delete();
      d = (mode[1] && seed == 32'd0) ? 32'd1 : seed;
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back(d);
         if (!(dup && i == int'(idx))) d = modelNext(mode, d);
      end
      stalls = 0; w = 0; k = 0;
      while (w < int'(len)) begin
         if (k < 32 && plan[k]) stalls++; else w++;
         k++;
      end
      exp_writes = (stop_kind == 0) ? int'(len) : stop_after;
      @(posedge clk_i); #1;
      writes_seen = 0; done_seen = 0; done_cyc = -1;
      mode_i = mode; seed_i = seed; length_i = len; dup_inject_i = dup; dup_index_i = idx;
      start_i = 1'b1;
      t0 = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(posedge clk_i); #1;
      // Scramble the run parameters; the generator must ignore them now
      seed_i = $urandom; length_i = 16'($urandom); mode_i = ~mode;
      dup_inject_i = ~dup; dup_index_i = 16'($urandom);
      k = 0; stopped = 0; budget = 0;
      while (!stopped && done_seen == 0 && budget < 200) begin
         fifo_full_i = (k < 32) ? plan[k] : 1'b0;
         if (stop_kind == 1 && writes_seen == stop_after) begin
            abort_i = 1'b1;
            @(posedge clk_i); #1;
            abort_i = 1'b0;
            stopped = 1;
         end else if (stop_kind == 2 && writes_seen == stop_after) begin
            #2 reset_n_i = 1'b0;
            #1;
            checkOutput("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
            checkOutput("rst_wr_data", fifo_wr_data_o, 32'd0);
            checkOutput("rst_busy", 32'(busy_o), 32'd0);
            checkOutput("rst_done", 32'(done_o), 32'd0);
            checkOutput("rst_words", 32'(words_o), 32'd0);
            checkOutput("rst_stall", 32'(stall_cnt_o), 32'd0);
            @(negedge clk_i);
            reset_n_i = 1'b1;
            stopped = 1;
         end else begin
            @(posedge clk_i); #1;
            k++;
            budget++;
         end
      end
      fifo_full_i = 1'b0;
      if (budget >= 200) checkOutput("run_timeout", 32'd1, 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("busy_after", 32'(busy_o), 32'd0);
      checkOutput("writes", 32'(writes_seen), 32'(exp_writes));
      checkOutput("words", 32'(words_o), (stop_kind == 2) ? 32'd0 : 32'(exp_writes));
      checkOutput("stall_cnt", 32'(stall_cnt_o), (stop_kind == 0) ? 32'(stalls) : 32'd0);
      checkOutput("done_pulses", 32'(done_seen), (stop_kind == 0) ? 32'd1 : 32'd0);
      checkOutput("words_left", 32'(exp_q.size()), 32'(int'(len) - exp_writes));
      if (stop_kind == 0) checkOutput("done_cycle", 32'(done_cyc), 32'(t0 + 2 + int'(len) + stalls));
   endtask

   initial begin
      #12;
      checkOutput("reset_wr_en", 32'(fifo_wr_en_o), 32'd0);
      checkOutput("reset_wr_data", fifo_wr_data_o, 32'd0);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_done", 32'(done_o), 32'd0);
      checkOutput("reset_words", 32'(words_o), 32'd0);
      checkOutput("reset_stall", 32'(stall_cnt_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      applyStimulus(2'b00, 32'h0000_0010, 16'd4, 1'b0, 16'd0, 32'h0, 0, 0);
      applyStimulus(2'b01, 32'h0000_0001, 16'd3, 1'b0, 16'd0, 32'b110, 0, 0);
      applyStimulus(2'b11, 32'h0000_0000, 16'd3, 1'b0, 16'd0, 32'h0, 0, 0);
      applyStimulus(2'b10, 32'h0000_0001, 16'd2, 1'b0, 16'd0, 32'h0, 0, 0);
      applyStimulus(2'b10, 32'h8000_0001, 16'd6, 1'b0, 16'd0, 32'b1010_0000, 0, 0);
      applyStimulus(2'b00, 32'h0000_0100, 16'd5, 1'b1, 16'd1, 32'h0, 0, 0);
      applyStimulus(2'b00, 32'hFFFF_FFFE, 16'd3, 1'b1, 16'd5, 32'h0, 0, 0);
      applyStimulus(2'b00, 32'h0000_0055, 16'd0, 1'b0, 16'd0, 32'h0, 0, 0);
      applyStimulus(2'b00, 32'h0000_0200, 16'd8, 1'b0, 16'd0, 32'h0, 1, 2);
      applyStimulus(2'b11, 32'h0000_0001, 16'd8, 1'b0, 16'd0, 32'h0, 2, 3);
      applyStimulus(2'b00, 32'h0000_0300, 16'd4, 1'b1, 16'd3, 32'b1, 0, 0);

      // start and abort together in IDLE must leave the generator idle
      @(posedge clk_i); #1;
      start_i = 1'b1; abort_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; abort_i = 1'b0;
      checkOutput("start_abort_idle", 32'(busy_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
